// File: rtl/pipe_pkg.sv
// Shared pipeline constants: writeback bundle layout and chain depth limit.
package pipe_pkg;

    localparam int ALU_W      = 32;
    localparam int MEMDATA_W  = 32;
    localparam int RW_W       = 5;
    localparam int WRCTRL_W   = 2;
    localparam int FPBUS_W    = 64;
    localparam int FPRW_W     = 5;
    localparam int FPREGWR_W  = 1;

    localparam int ALU_OFS     = 0;
    localparam int MEMDATA_OFS = ALU_OFS + ALU_W;
    localparam int RW_OFS      = MEMDATA_OFS + MEMDATA_W;
    localparam int WRCTRL_OFS  = RW_OFS + RW_W;
    localparam int FPBUS_OFS   = WRCTRL_OFS + WRCTRL_W;
    localparam int FPRW_OFS    = FPBUS_OFS + FPBUS_W;
    localparam int FPREGWR_OFS = FPRW_OFS + FPRW_W;

    localparam int WB_BUNDLE_W = FPREGWR_OFS + FPREGWR_W;  // 141
    localparam int MAX_DEPTH   = 8;

    // Field order is MSB first, so alu lands at bit 0 to match the offsets above.
    typedef struct packed {
        logic [FPREGWR_W-1:0] fpregwr;
        logic [FPRW_W-1:0]    fprw;
        logic [FPBUS_W-1:0]   fpbus;
        logic [WRCTRL_W-1:0]  wrctrl;
        logic [RW_W-1:0]      rw;
        logic [MEMDATA_W-1:0] memdata;
        logic [ALU_W-1:0]     alu;
    } wb_bundle_t;

    function automatic logic [3:0] popcount(input logic [MAX_DEPTH-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < MAX_DEPTH; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One chain slot: a valid bit plus payload register with load enable and flush.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int WIDTH = WB_BUNDLE_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic             src_valid_i,
    input  logic [WIDTH-1:0] src_data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    // Flush only kills the valid bit; the payload register keeps its contents.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = src_valid_i;
            data_d  = src_data_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic valid/ready register chain of DEPTH slots with flush and bubble collapse.
// Optional saturating stall counter enabled by PIPE_STALL_CNT_EN.
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter  int WIDTH = WB_BUNDLE_W,
    parameter  int DEPTH = 1,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    logic [DEPTH:0]                rdy;
    logic [DEPTH-1:0]              v;
    logic [DEPTH-1:0][WIDTH-1:0]   d;
    logic [DEPTH-1:0]              src_v;
    logic [DEPTH-1:0][WIDTH-1:0]   src_d;
    logic [MAX_DEPTH-1:0]          v_ext;

    // A slot may load when it is empty or the slot ahead of it will move.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) rdy[k] = !v[k] | rdy[k+1];
    end

    assign src_v[0] = in_valid;
    assign src_d[0] = in_data;

    for (genvar k = 1; k < DEPTH; k++) begin : g_src
        assign src_v[k] = v[k-1];
        assign src_d[k] = d[k-1];
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        pipe_slot #(.WIDTH(WIDTH)) u_slot (
            .clk         (clk),
            .reset       (reset),
            .flush_i     (flush),
            .load_i      (rdy[k]),
            .src_valid_i (src_v[k]),
            .src_data_i  (src_d[k]),
            .valid_o     (v[k]),
            .data_o      (d[k])
        );
    end

    assign in_ready  = rdy[0] & !flush;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    always_comb begin
        v_ext            = '0;
        v_ext[DEPTH-1:0] = v;
    end

    assign occupancy = OCC_W'(popcount(v_ext));

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturates; flush deliberately leaves the count alone.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Drives four chains (DEPTH 1..4) with shared stimulus; checks each against an occupancy/FIFO model.
module tb_pipe_reg_chain;

    localparam int W  = 40;
    localparam int ND = 4;

    logic clk;
    logic reset;
    logic flush, in_valid, out_ready;
    logic [W-1:0] in_data;

    logic [ND-1:0]        ir_a, ov_a;
    logic [ND-1:0][W-1:0] od_a;
    logic [ND-1:0][3:0]   occ_a;
`ifdef PIPE_STALL_CNT_EN
    logic [ND-1:0][31:0]  sc_a;
`endif

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int D = g + 1;
        logic [$clog2(D+1)-1:0] occ;
        logic                   irdy, ovld;
        logic [W-1:0]           odat;

        pipe_reg_chain #(.WIDTH(W), .DEPTH(D)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .in_valid  (in_valid),
            .in_ready  (irdy),
            .in_data   (in_data),
            .out_valid (ovld),
            .out_ready (out_ready),
            .out_data  (odat),
            .occupancy (occ)
`ifdef PIPE_STALL_CNT_EN
            ,
            .stall_cnt (sc_a[g])
`endif
        );

        assign ir_a[g]  = irdy;
        assign ov_a[g]  = ovld;
        assign od_a[g]  = odat;
        assign occ_a[g] = 4'(occ);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Model: which slots hold entries, plus an in-order FIFO of accepted payloads.
    bit          mv   [ND][8];
    logic [W-1:0] fifo [ND][16];
    int          hd [ND], tl [ND];
    int          acc[ND], del[ND], fls[ND];
    int          scnt[ND];

    function automatic int m_occ(input int d);
        int n = 0;
        for (int k = 0; k <= d; k++) n += int'(mv[d][k]);
        return n;
    endfunction

    task automatic m_clear();
        for (int d = 0; d < ND; d++) begin
            for (int k = 0; k < 8; k++) mv[d][k] = 1'b0;
            hd[d] = 0; tl[d] = 0; acc[d] = 0; del[d] = 0; fls[d] = 0; scnt[d] = 0;
        end
    endtask

    // Entered just after a rising edge; checks pre-edge outputs, then advances the model.
    task automatic step(input bit iv, input logic [W-1:0] id, input bit ordy, input bit fl);
        bit eo[ND];
        bit ei[ND];
        int oc[ND];
        in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
        #3;
        for (int d = 0; d < ND; d++) begin
            oc[d] = m_occ(d);
            eo[d] = mv[d][d];
            ei[d] = !fl && (ordy || oc[d] < d + 1);
            chk($sformatf("d%0d in_ready", d + 1),  64'(ir_a[d]),  64'(ei[d]));
            chk($sformatf("d%0d out_valid", d + 1), 64'(ov_a[d]),  64'(eo[d]));
            chk($sformatf("d%0d occupancy", d + 1), 64'(occ_a[d]), 64'(oc[d]));
            chk($sformatf("d%0d occ_balance", d + 1), 64'(occ_a[d]),
                64'(acc[d] - del[d] - fls[d]));
            if (eo[d])
                chk($sformatf("d%0d out_data", d + 1), 64'(od_a[d]), 64'(fifo[d][hd[d] % 16]));
`ifdef PIPE_STALL_CNT_EN
            chk($sformatf("d%0d stall_cnt", d + 1), 64'(sc_a[d]), 64'(scnt[d]));
`endif
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            bit old[8];
            bit xout;
            xout = eo[d] && ordy;
            if (eo[d] && !ordy) scnt[d]++;
            if (xout) begin hd[d]++; del[d]++; end
            if (fl) begin
                fls[d] += oc[d] - int'(xout);
                for (int k = 0; k < 8; k++) mv[d][k] = 1'b0;
                hd[d] = tl[d];
            end else begin
                for (int k = 0; k < 8; k++) old[k] = mv[d][k];
                // An entry moves forward whenever any slot at or beyond it is free, or the head drains.
                for (int k = d; k >= 0; k--) begin
                    bit go = ordy;
                    for (int j = k; j <= d; j++) if (!old[j]) go = 1'b1;
                    if (go) mv[d][k] = (k == 0) ? iv : old[k-1];
                end
                if (iv && ei[d]) begin
                    fifo[d][tl[d] % 16] = id;
                    tl[d]++;
                    acc[d]++;
                end
            end
        end
    endtask

    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("d%0d rst out_valid", d + 1), 64'(ov_a[d]),  64'd0);
            chk($sformatf("d%0d rst out_data", d + 1),  64'(od_a[d]),  64'd0);
            chk($sformatf("d%0d rst occupancy", d + 1), 64'(occ_a[d]), 64'd0);
`ifdef PIPE_STALL_CNT_EN
            chk($sformatf("d%0d rst stall_cnt", d + 1), 64'(sc_a[d]), 64'd0);
`endif
        end
        m_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [W-1:0] rnd_data();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return W'(r);
    endfunction

    initial begin
        reset = 1'b1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        m_clear();
        @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("d%0d init out_valid", d + 1), 64'(ov_a[d]),  64'd0);
            chk($sformatf("d%0d init out_data", d + 1),  64'(od_a[d]),  64'd0);
            chk($sformatf("d%0d init occupancy", d + 1), 64'(occ_a[d]), 64'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Streaming: DEPTH=2 shows 0x1 after two edges, then one per cycle.
        step(1'b1, W'(1), 1'b1, 1'b0);
        step(1'b1, W'(2), 1'b1, 1'b0);
        chk("d2 stream first valid", 64'(ov_a[1]), 64'd1);
        chk("d2 stream first data",  64'(od_a[1]), 64'h1);
        step(1'b1, W'(3), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Stalled fill: DEPTH=3 takes three of four, then drains in order.
        for (int i = 0; i < 4; i++) step(1'b1, W'(32'h10 + i), 1'b0, 1'b0);
        chk("d3 full in_ready",  64'(ir_a[2]),  64'd0);
        chk("d3 full occupancy", 64'(occ_a[2]), 64'd3);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Bubble collapse behind a stalled head.
        step(1'b1, W'(32'h20), 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("d3 bubble head", 64'(occ_a[2]), 64'd1);
        step(1'b1, W'(32'h21), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("d3 bubble occupancy", 64'(occ_a[2]), 64'd2);
        chk("d3 bubble in_ready",  64'(ir_a[2]),  64'd1);
        chk("d3 bubble out_data",  64'(od_a[2]),  64'h20);
        step(1'b1, W'(32'h22), 1'b0, 1'b0);
        chk("d3 refull occupancy", 64'(occ_a[2]), 64'd3);

        // Flush a full chain while presenting input.
        step(1'b1, W'(32'hDEAD), 1'b0, 1'b1);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("d%0d flush out_valid", d + 1), 64'(ov_a[d]),  64'd0);
            chk($sformatf("d%0d flush occupancy", d + 1), 64'(occ_a[d]), 64'd0);
        end
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);

`ifdef PIPE_STALL_CNT_EN
        async_reset();
        step(1'b1, W'(32'h30), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b0);
        chk("d1 stall_cnt", 64'(sc_a[0]), 64'd5);
        step(1'b0, '0, 1'b1, 1'b1);
        chk("d1 stall_cnt after flush", 64'(sc_a[0]), 64'd5);
`endif

        // Reset between edges while entries are in flight.
        for (int i = 0; i < 3; i++) step(1'b1, rnd_data(), 1'b0, 1'b0);
        async_reset();

        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                step(1'b1, rnd_data(), 1'b0, 1'b0);
                async_reset();
            end
            step($urandom_range(0, 3) != 0, rnd_data(),
                 $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
